// File: rtl/data_bus_responder_pkg.sv
// Shared encodings for the data-bus responder: access sizes, FSM states
// and the wait-state ceiling.
package data_bus_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // The wait counter is 4 bits wide, so this is the largest usable value.
    localparam int unsigned WAIT_STATES_MAX = 15;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/data_bus_responder_lane_align.sv
// bus_lane_align: combinational byte-lane steering for the data-bus responder.
// Produces store byte-enables plus the replicated store word, and the
// lane-extracted, sign/zero-extended load value.
module bus_lane_align
    import data_bus_responder_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_f;
    logic [15:0] half_f;

    // Lane selection; addresses below the access size are ignored here, since
    // misaligned rejection happens upstream.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        byte_f  = rword_i[8*addr_lo_i +: 8];
        half_f  = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (size_i)
            SIZE_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                // Replicating the byte puts it in every lane; the enable picks one.
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & byte_f[7]}}, byte_f};
            end
            SIZE_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{~unsigned_i & half_f[15]}}, half_f};
            end
            SIZE_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: data-memory responder with configurable wait states,
// byte/half/word lane steering and load extension. Owns the data RAM.
// Optional feature macro: DATA_BUS_RESPONDER_MISALIGN_EN (reject misaligned
// half/word accesses instead of ignoring the low address bits).
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int unsigned MEM_DATA_ADDR_WIDTH = 12,
    parameter int unsigned WAIT_STATES         = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wd,
    input  logic                           rd,
    input  logic [1:0]                     size,
    input  logic                           unsigned_value,
    input  logic [MEM_DATA_ADDR_WIDTH-1:0] addr,
    input  logic [31:0]                    data_in,
    output logic [31:0]                    data_out,
    output logic                           ready,
    output logic                           fault
);

    localparam int unsigned Depth   = 2 ** (MEM_DATA_ADDR_WIDTH - 2);
    localparam int unsigned WaitEff =
        (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
    localparam logic [3:0]  WaitInit = (WaitEff > 0) ? 4'(WaitEff - 1) : 4'd0;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic                           req_wd_q, req_rd_q, req_uns_q;
    logic [1:0]                     req_size_q;
    logic [MEM_DATA_ADDR_WIDTH-1:0] req_addr_q;
    logic [31:0]                    req_data_q;

    logic [31:0] data_out_q;
    logic        fault_q;

    logic                           eff_wd, eff_rd, eff_uns, eff_fault;
    logic [1:0]                     eff_size;
    logic [MEM_DATA_ADDR_WIDTH-1:0] eff_addr;
    logic [31:0]                    eff_data;

    logic        req;
    logic        commit;
    logic [3:0]  be;
    logic [31:0] wdata_shift;
    logic [31:0] rdata_ext;
    logic [31:0] rword;

    logic [31:0] mem [Depth];

    assign req = rd | wd;

    // With zero wait states the commit happens from IDLE, before the request
    // registers are loaded, so the live inputs are used in that state.
    always_comb begin
        if (state_q == StIdle) begin
            eff_wd   = wd;
            eff_rd   = rd;
            eff_uns  = unsigned_value;
            eff_size = size;
            eff_addr = addr;
            eff_data = data_in;
        end else begin
            eff_wd   = req_wd_q;
            eff_rd   = req_rd_q;
            eff_uns  = req_uns_q;
            eff_size = req_size_q;
            eff_addr = req_addr_q;
            eff_data = req_data_q;
        end
    end

    // Fault detection for the access being committed.
    always_comb begin
        eff_fault = (eff_size == 2'b11) || (eff_rd && eff_wd);
`ifdef DATA_BUS_RESPONDER_MISALIGN_EN
        if ((eff_size == SIZE_HALF) && eff_addr[0]) begin
            eff_fault = 1'b1;
        end
        if ((eff_size == SIZE_WORD) && (eff_addr[1:0] != 2'b00)) begin
            eff_fault = 1'b1;
        end
`endif
    end

    assign rword = mem[eff_addr[MEM_DATA_ADDR_WIDTH-1:2]];

    bus_lane_align u_lane_align (
        .addr_lo_i  (eff_addr[1:0]),
        .size_i     (eff_size),
        .unsigned_i (eff_uns),
        .wdata_i    (eff_data),
        .rword_i    (rword),
        .be_o       (be),
        .wdata_o    (wdata_shift),
        .rdata_o    (rdata_ext)
    );

    // Next-state logic; commit marks the edge that enters RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (WaitEff == 0) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            data_out_q <= 32'h0;
            fault_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                fault_q <= eff_fault;
                if (eff_fault) begin
                    data_out_q <= 32'h0;
                end else if (eff_rd) begin
                    data_out_q <= rdata_ext;
                end
            end else if (state_q == StResp) begin
                fault_q <= 1'b0;
            end
        end
    end

    // Request capture, only while idle so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_wd_q   <= 1'b0;
            req_rd_q   <= 1'b0;
            req_uns_q  <= 1'b0;
            req_size_q <= SIZE_BYTE;
            req_addr_q <= '0;
            req_data_q <= 32'h0;
        end else if ((state_q == StIdle) && req) begin
            req_wd_q   <= wd;
            req_rd_q   <= rd;
            req_uns_q  <= unsigned_value;
            req_size_q <= size;
            req_addr_q <= addr;
            req_data_q <= data_in;
        end
    end

    // RAM write port; no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (!rst && commit && eff_wd && !eff_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[eff_addr[MEM_DATA_ADDR_WIDTH-1:2]][8*i +: 8] <= wdata_shift[8*i +: 8];
                end
            end
        end
    end

    assign ready    = ((state_q == StIdle) && !req) || (state_q == StResp);
    assign data_out = data_out_q;
    assign fault    = fault_q;

endmodule
